alarm_buzzer_seq: RTL and testbench



---
 rtl/alarm_buzzer_seq.sv | 171 +++++++++++++++++
 tb/tb_alarm_buzzer_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_buzzer_seq.sv
// Alarm sounder sequencer: turns the level alarm request into a gated beep
// pattern (four 100 ms bursts per second) with snooze, dismiss and ring timeout.
module alarm_buzzer_seq #(
  parameter int CLK_HZ     = 31500000,
  parameter int TONE_HZ    = 3150,
  parameter int SNOOZE_S   = 60,
  parameter int RING_MAX_S = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic alarm_req,
  input  logic snooze,
  input  logic dismiss,
  output logic buzzer_out,
  output logic ringing,
  output logic snoozing
);

  localparam int PRE_DIV  = CLK_HZ / 1000;
  localparam int HALF_DIV = CLK_HZ / (2 * TONE_HZ);
  localparam int PRE_W    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int HALF_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(PRE_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(HALF_DIV - 1);
  localparam logic [9:0]        FRAME_LAST  = 10'd999;
  localparam logic [7:0]        RING_LAST   = 8'(RING_MAX_S - 1);
  localparam logic [7:0]        SNOOZE_LAST = 8'(SNOOZE_S - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RING      = 2'd1,
    S_SNOOZE    = 2'd2,
    S_DISMISSED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PRE_W-1:0]   r_presc;
  logic [9:0]         r_frame;
  logic [7:0]         r_ring_sec;
  logic [7:0]         r_snooze_sec;
  logic [HALF_W-1:0]  r_half;
  logic               r_tone;
  logic               w_ms_tick;
  logic               w_sec_wrap;
  logic               w_ring_timeout;
  logic               w_snooze_done;
  logic               w_timing_active;
  logic               w_enter_ring;
  logic               w_enter_snooze;
  logic               w_gate;

  // Timeouts fire on the edge that completes the last second, not one later
  always_comb begin
    w_ms_tick       = (r_presc == PRE_LAST);
    w_sec_wrap      = w_ms_tick && (r_frame == FRAME_LAST);
    w_ring_timeout  = w_sec_wrap && (r_ring_sec == RING_LAST);
    w_snooze_done   = w_sec_wrap && (r_snooze_sec == SNOOZE_LAST);
    w_timing_active = (r_state == S_RING) || (r_state == S_SNOOZE);
    w_enter_ring    = (w_state_nxt == S_RING) && (r_state != S_RING);
    w_enter_snooze  = (w_state_nxt == S_SNOOZE) && (r_state != S_SNOOZE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode in the listed priority order
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (alarm_req) w_state_nxt = S_RING;
        else           w_state_nxt = S_IDLE;
      end
      S_RING: begin
        if (dismiss)             w_state_nxt = S_DISMISSED;
        else if (snooze)         w_state_nxt = S_SNOOZE;
        else if (!alarm_req)     w_state_nxt = S_IDLE;
        else if (w_ring_timeout) w_state_nxt = S_DISMISSED;
        else                     w_state_nxt = S_RING;
      end
      S_SNOOZE: begin
        if (dismiss)            w_state_nxt = S_DISMISSED;
        else if (!alarm_req)    w_state_nxt = S_IDLE;
        else if (w_snooze_done) w_state_nxt = S_RING;
        else                    w_state_nxt = S_SNOOZE;
      end
      S_DISMISSED: begin
        if (!alarm_req) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_DISMISSED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ms prescaler and frame counter; frame also restarts on SNOOZE entry so expiry is exact
  always_ff @(posedge clk) begin
    if (reset || w_enter_ring || w_enter_snooze || !w_timing_active) begin
      r_presc <= {PRE_W{1'b0}};
      r_frame <= 10'd0;
    end else if (w_ms_tick) begin
      r_presc <= {PRE_W{1'b0}};
      r_frame <= (r_frame == FRAME_LAST) ? 10'd0 : r_frame + 10'd1;
    end else begin
      r_presc <= r_presc + PRE_W'(1);
      r_frame <= r_frame;
    end
  end

  // Second counters, one per timed state, saturating
  always_ff @(posedge clk) begin
    if (reset || w_enter_ring) begin
      r_ring_sec <= 8'd0;
    end else if ((r_state == S_RING) && w_sec_wrap && (r_ring_sec != 8'hFF)) begin
      r_ring_sec <= r_ring_sec + 8'd1;
    end else begin
      r_ring_sec <= r_ring_sec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_enter_snooze) begin
      r_snooze_sec <= 8'd0;
    end else if ((r_state == S_SNOOZE) && w_sec_wrap && (r_snooze_sec != 8'hFF)) begin
      r_snooze_sec <= r_snooze_sec + 8'd1;
    end else begin
      r_snooze_sec <= r_snooze_sec;
    end
  end

  // Tone generator: starts on a high half-period at every RING entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_half <= {HALF_W{1'b0}};
      r_tone <= 1'b0;
    end else if (w_enter_ring) begin
      r_half <= {HALF_W{1'b0}};
      r_tone <= 1'b1;
    end else if (r_state == S_RING) begin
      if (r_half == HALF_LAST) begin
        r_half <= {HALF_W{1'b0}};
        r_tone <= ~r_tone;
      end else begin
        r_half <= r_half + HALF_W'(1);
        r_tone <= r_tone;
      end
    end else begin
      r_half <= r_half;
      r_tone <= r_tone;
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    w_gate = (r_frame < 10'd100) ||
             ((r_frame >= 10'd200) && (r_frame < 10'd300)) ||
             ((r_frame >= 10'd400) && (r_frame < 10'd500)) ||
             ((r_frame >= 10'd600) && (r_frame < 10'd700));
    ringing    = (r_state == S_RING);
    snoozing   = (r_state == S_SNOOZE);
    buzzer_out = (r_state == S_RING) && w_gate && r_tone;
  end

endmodule

// File: tb/tb_alarm_buzzer_seq.sv
// Bench for alarm_buzzer_seq: two instances run side by side so the long ring
// timeout overlaps the snooze and random scenarios; both follow a timing model.
module tb_alarm_buzzer_seq;

  localparam int P_CLK  = 20000;
  localparam int P_TONE = 1000;
  localparam int P_SNZ  = 2;
  localparam int P_RMAX = 3;
  localparam int CYC_MS = P_CLK / 1000;
  localparam int HALF   = P_CLK / (2 * P_TONE);

  localparam int M_IDLE   = 0;
  localparam int M_RING   = 1;
  localparam int M_SNOOZE = 2;
  localparam int M_DONE   = 3;

  logic clk = 1'b0;
  logic reset0, alarm0, snooze0, dismiss0, buzz0, ring0, snz0;
  logic reset1, alarm1, snooze1, dismiss1, buzz1, ring1, snz1;

  int n_vec  = 0;
  int n_miss = 0;
  int m_mode0 = M_IDLE;
  int m_t0    = 0;
  int m_mode1 = M_IDLE;
  int m_t1    = 0;

  always #5 clk = ~clk;

  alarm_buzzer_seq #(.CLK_HZ(P_CLK), .TONE_HZ(P_TONE), .SNOOZE_S(P_SNZ), .RING_MAX_S(P_RMAX)) u_dut0 (
    .clk(clk), .reset(reset0), .alarm_req(alarm0), .snooze(snooze0), .dismiss(dismiss0),
    .buzzer_out(buzz0), .ringing(ring0), .snoozing(snz0)
  );

  alarm_buzzer_seq #(.CLK_HZ(P_CLK), .TONE_HZ(P_TONE), .SNOOZE_S(P_SNZ), .RING_MAX_S(P_RMAX)) u_dut1 (
    .clk(clk), .reset(reset1), .alarm_req(alarm1), .snooze(snooze1), .dismiss(dismiss1),
    .buzzer_out(buzz1), .ringing(ring1), .snoozing(snz1)
  );

  // Reference: mode plus cycles elapsed since entering it
  function automatic logic [63:0] model_next(input int mode, input int t, input logic rst,
                                              input logic a, input logic sn, input logic di);
    int nm;
    int nt;
    nm = mode;
    nt = t;
    if (rst) begin
      nm = M_IDLE;
      nt = 0;
    end else begin
      case (mode)
        M_IDLE: if (a) begin nm = M_RING; nt = 0; end
        M_RING: begin
          if (di)                          nm = M_DONE;
          else if (sn)                     begin nm = M_SNOOZE; nt = 0; end
          else if (!a)                     nm = M_IDLE;
          else if (t + 1 >= P_RMAX * P_CLK) nm = M_DONE;
          else                             nt = t + 1;
        end
        M_SNOOZE: begin
          if (di)                         nm = M_DONE;
          else if (!a)                    nm = M_IDLE;
          else if (t + 1 >= P_SNZ * P_CLK) begin nm = M_RING; nt = 0; end
          else                            nt = t + 1;
        end
        default: if (!a) nm = M_IDLE;
      endcase
    end
    return {nm, nt};
  endfunction

  function automatic logic [2:0] model_out(input int mode, input int t);
    int   ms;
    logic gate;
    logic tone;
    ms   = (t / CYC_MS) % 1000;
    gate = (ms < 700) && ((ms % 200) < 100);
    tone = ((t / HALF) % 2) == 0;
    return {(mode == M_RING) && gate && tone, mode == M_RING, mode == M_SNOOZE};
  endfunction

  always @(posedge clk) begin
    {m_mode0, m_t0} <= model_next(m_mode0, m_t0, reset0, alarm0, snooze0, dismiss0);
    {m_mode1, m_t1} <= model_next(m_mode1, m_t1, reset1, alarm1, snooze1, dismiss1);
  end

  task automatic test_reset();
    reset0 = 1'b1; alarm0 = 1'b1; snooze0 = 1'b0; dismiss0 = 1'b0;
    reset1 = 1'b1; alarm1 = 1'b1; snooze1 = 1'b0; dismiss1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({buzz0, ring0, snz0} !== 3'b000) begin
        n_miss++; $display("FAIL reset_hold0 i=%0d got %b want 000", i, {buzz0, ring0, snz0});
      end
      n_vec++;
      if ({buzz1, ring1, snz1} !== 3'b000) begin
        n_miss++; $display("FAIL reset_hold1 i=%0d got %b want 000", i, {buzz1, ring1, snz1});
      end
    end
    reset0 = 1'b0;
    reset1 = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({buzz0, ring0, snz0} !== 3'b110) begin
      n_miss++; $display("FAIL reset_release0 got %b want 110", {buzz0, ring0, snz0});
    end
    n_vec++;
    if ({buzz1, ring1, snz1} !== 3'b110) begin
      n_miss++; $display("FAIL reset_release1 got %b want 110", {buzz1, ring1, snz1});
    end
  endtask

  // Cycle c is the interval after clock edge c-1 counted from RING entry at edge 0
  task automatic test_ring_timeout();
    logic [2:0] exp;
    for (int c = 2; c <= 60120; c++) begin
      @(negedge clk);
      exp = model_out(m_mode0, m_t0);
      n_vec++;
      if ({buzz0, ring0, snz0} !== exp) begin
        n_miss++; $display("FAIL timeout_model c=%0d got %b want %b", c, {buzz0, ring0, snz0}, exp);
      end
      if (c inside {10, 21, 4001, 8001, 12001, 20001, 60104}) begin
        n_vec++;
        if (buzz0 !== 1'b1) begin
          n_miss++; $display("FAIL pattern_high c=%0d got %b want 1", c, buzz0);
        end
      end
      if (c inside {11, 2001, 3999, 14001, 19999}) begin
        n_vec++;
        if (buzz0 !== 1'b0) begin
          n_miss++; $display("FAIL pattern_low c=%0d got %b want 0", c, buzz0);
        end
      end
      if (c inside {60000, 60001, 60099, 60104}) begin
        n_vec++;
        if (ring0 !== ((c == 60000) || (c == 60104))) begin
          n_miss++; $display("FAIL timeout_ringing c=%0d got %b", c, ring0);
        end
      end
      alarm0 = !((c >= 60100) && (c < 60103));
    end
  endtask

  task automatic test_snooze();
    logic [2:0] exp;
    for (int c = 2; c <= 45030; c++) begin
      @(negedge clk);
      exp = model_out(m_mode1, m_t1);
      n_vec++;
      if ({buzz1, ring1, snz1} !== exp) begin
        n_miss++; $display("FAIL snooze_model c=%0d got %b want %b", c, {buzz1, ring1, snz1}, exp);
      end
      if (c inside {5001, 45000}) begin
        n_vec++;
        if ({buzz1, ring1, snz1} !== 3'b001) begin
          n_miss++; $display("FAIL snooze_state c=%0d got %b want 001", c, {buzz1, ring1, snz1});
        end
      end
      if (c == 45001) begin
        n_vec++;
        if ({buzz1, ring1, snz1} !== 3'b110) begin
          n_miss++; $display("FAIL snooze_rering c=%0d got %b want 110", c, {buzz1, ring1, snz1});
        end
      end
      snooze1 = (c == 5000) || (c == 20000);
    end
    snooze1 = 1'b0;
  endtask

  task automatic test_dismiss_pair();
    logic [2:0] exp;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      exp = model_out(m_mode1, m_t1);
      n_vec++;
      if ({buzz1, ring1, snz1} !== exp) begin
        n_miss++; $display("FAIL pair_model k=%0d got %b want %b", k, {buzz1, ring1, snz1}, exp);
      end
      if (k inside {6, 39}) begin
        n_vec++;
        if ({buzz1, ring1, snz1} !== 3'b000) begin
          n_miss++; $display("FAIL pair_dismissed k=%0d got %b want 000", k, {buzz1, ring1, snz1});
        end
      end
      if (k == 43) begin
        n_vec++;
        if (ring1 !== 1'b1) begin
          n_miss++; $display("FAIL pair_rering k=%0d got %b want 1", k, ring1);
        end
      end
      snooze1  = (k == 5);
      dismiss1 = (k == 5);
      alarm1   = !((k == 40) || (k == 41));
    end
  endtask

  task automatic test_snooze_drop();
    logic [2:0] exp;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp = model_out(m_mode1, m_t1);
      n_vec++;
      if ({buzz1, ring1, snz1} !== exp) begin
        n_miss++; $display("FAIL drop_model k=%0d got %b want %b", k, {buzz1, ring1, snz1}, exp);
      end
      if (k inside {6, 10, 11, 16, 30, 34}) begin
        n_vec++;
        if ({buzz1, ring1, snz1} !== ((k <= 10) ? 3'b001 : ((k == 11) || (k == 30)) ? 3'b000 : 3'b110)) begin
          n_miss++; $display("FAIL drop_state k=%0d got %b", k, {buzz1, ring1, snz1});
        end
      end
      snooze1  = (k == 5);
      dismiss1 = (k == 25);
      alarm1   = !(((k >= 10) && (k < 15)) || (k == 25) || (k == 32));
    end
    dismiss1 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] exp;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      exp = model_out(m_mode1, m_t1);
      n_vec++;
      if ({buzz1, ring1, snz1} !== exp) begin
        n_miss++; $display("FAIL rstmid_model k=%0d got %b want %b", k, {buzz1, ring1, snz1}, exp);
      end
      if (k inside {51, 53, 54, 64, 74}) begin
        n_vec++;
        if ({buzz1, ring1, snz1} !== ((k <= 53) ? 3'b000 : (k == 64) ? 3'b010 : 3'b110)) begin
          n_miss++; $display("FAIL rstmid_state k=%0d got %b", k, {buzz1, ring1, snz1});
        end
      end
      reset1 = (k >= 50) && (k < 53);
    end
  endtask

  task automatic test_random();
    logic [2:0] exp;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      exp = model_out(m_mode1, m_t1);
      n_vec++;
      if ({buzz1, ring1, snz1} !== exp) begin
        n_miss++; $display("FAIL random_model k=%0d got %b want %b", k, {buzz1, ring1, snz1}, exp);
      end
      reset1   = ($urandom_range(0, 399) == 0);
      alarm1   = ($urandom_range(0, 99) >= 8);
      snooze1  = ($urandom_range(0, 99) < 2);
      dismiss1 = ($urandom_range(0, 149) == 0);
    end
    reset1 = 1'b0; snooze1 = 1'b0; dismiss1 = 1'b0;
  endtask

  initial begin
    test_reset();
    fork
      test_ring_timeout();
      begin
        test_snooze();
        test_dismiss_pair();
        test_snooze_drop();
        test_reset_mid_burst();
        test_random();
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
